// File: rtl/tdm_demux_e.sv
// tdm_demux_e: two-lane TDM serial-to-parallel demultiplexer with enable.
// Each enabled bit is shifted into the lane chosen by sel once the frame is
// locked by an enabled sync. Completed words are presented with one-cycle
// valid strobes.
// Optional feature macro: TDM_DEMUX_PARITY_EN (trailing even-parity bit per word).
module tdm_demux_e #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             sel,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] a_word,
  output logic             a_valid,
  output logic [WIDTH-1:0] b_word,
  output logic             b_valid,
  output logic             frame_err,
  output logic             par_err
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif
  localparam int unsigned CW = $clog2(N);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d;
  logic [CW-1:0]    a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [WIDTH-1:0] a_word_q, a_word_d, b_word_q, b_word_d;
  logic             a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             par_err_q, par_err_d;

  logic             consume;
  logic [CW-1:0]    cnt_cur, cnt_nxt;
  logic [WIDTH-1:0] sr_cur, sr_nxt, word_out;
  logic             last_bit, word_ok;

  // Per-lane datapath: pick the addressed lane's state and compute its update
  always_comb begin
    cnt_cur  = sync ? '0 : (sel ? b_cnt_q : a_cnt_q);
    sr_cur   = sel ? b_sr_q : a_sr_q;
    sr_nxt   = {sr_cur[WIDTH-2:0], din};
    last_bit = (cnt_cur == CW'(N - 1));
    cnt_nxt  = last_bit ? '0 : cnt_cur + CW'(1);
`ifdef TDM_DEMUX_PARITY_EN
    // Data bits already sit in the shift register; din is the parity bit
    word_out = sr_cur;
    word_ok  = ~((^sr_cur) ^ din);
`else
    word_out = sr_nxt;
    word_ok  = 1'b1;
`endif
  end

  // Next-state logic: lock FSM, lane counters/shifters, strobes
  always_comb begin
    state_d     = state_q;
    a_sr_d      = a_sr_q;
    b_sr_d      = b_sr_q;
    a_cnt_d     = a_cnt_q;
    b_cnt_d     = b_cnt_q;
    a_word_d    = a_word_q;
    b_word_d    = b_word_q;
    a_valid_d   = 1'b0;
    b_valid_d   = 1'b0;
    frame_err_d = 1'b0;
    par_err_d   = 1'b0;
    consume     = 1'b0;

    if (en) begin
      if (sync) begin
        // Resync: drop any partial words and restart both lanes at bit 0
        if (state_q == LOCKED && (a_cnt_q != '0 || b_cnt_q != '0)) begin
          frame_err_d = 1'b1;
        end
        a_cnt_d = '0;
        b_cnt_d = '0;
        state_d = LOCKED;
        consume = 1'b1;
      end else if (state_q == LOCKED) begin
        consume = 1'b1;
      end
    end

    if (consume) begin
      if (sel) begin
        b_sr_d  = sr_nxt;
        b_cnt_d = cnt_nxt;
        if (last_bit && word_ok) begin
          b_word_d  = word_out;
          b_valid_d = 1'b1;
        end
      end else begin
        a_sr_d  = sr_nxt;
        a_cnt_d = cnt_nxt;
        if (last_bit && word_ok) begin
          a_word_d  = word_out;
          a_valid_d = 1'b1;
        end
      end
      if (last_bit && !word_ok) begin
        par_err_d = 1'b1;
      end
    end
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      a_word_q    <= '0;
      b_word_q    <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      a_word_q    <= a_word_d;
      b_word_q    <= b_word_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      frame_err_q <= frame_err_d;
      par_err_q   <= par_err_d;
    end
  end

  assign a_word    = a_word_q;
  assign a_valid   = a_valid_q;
  assign b_word    = b_word_q;
  assign b_valid   = b_valid_q;
  assign frame_err = frame_err_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_e.sv
// Directed self-checking bench for tdm_demux_e (WIDTH = 8).
module tb_tdm_demux_e;

  localparam int unsigned W = 8;

  logic         clk, rst, din, sel, en, sync;
  logic [W-1:0] a_word, b_word;
  logic         a_valid, b_valid, frame_err, par_err;

  int tests = 0;
  int fails = 0;

  tdm_demux_e #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .en(en), .sync(sync),
    .a_word(a_word), .a_valid(a_valid), .b_word(b_word), .b_valid(b_valid),
    .frame_err(frame_err), .par_err(par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, return just after the rising edge
  task automatic step(input logic s, input logic d, input logic e, input logic sy);
    @(negedge clk);
    sel = s; din = d; en = e; sync = sy;
    @(posedge clk);
    #1;
  endtask

  // Send one word MSB first on lane s, plus a parity bit when enabled
  task automatic send_word(input logic s, input logic [W-1:0] w, input logic sy, input logic bad_par);
    for (int i = W - 1; i >= 0; i--) begin
      step(s, w[i], 1'b1, sy && (i == W - 1));
    end
`ifdef TDM_DEMUX_PARITY_EN
    step(s, (^w) ^ bad_par, 1'b1, 1'b0);
`else
    if (bad_par) $display("[TB] parity request ignored in this build");
`endif
  endtask

`ifdef TDM_DEMUX_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  initial begin
    logic [NB-1:0] abits, bbits;
    logic [W-1:0]  av, bv;
    av = 8'h3C;
    bv = 8'hC3;
`ifdef TDM_DEMUX_PARITY_EN
    abits = {av, ^av};
    bbits = {bv, ^bv};
`else
    abits = av;
    bbits = bv;
`endif

    rst = 1'b1; din = 1'b0; sel = 1'b0; en = 1'b0; sync = 1'b0;
    #12;
    chk("rst_a_word", 32'(a_word), 32'h0);
    chk("rst_b_word", 32'(b_word), 32'h0);
    chk("rst_strobes", {28'h0, a_valid, b_valid, frame_err, par_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Unlocked: bits without sync are discarded
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'(i % 2), 1'b1, 1'b0);
      chk("unlocked_no_valid", {30'h0, a_valid, b_valid}, 32'h0);
    end
    chk("unlocked_a_word", 32'(a_word), 32'h0);

    // Lock on lane A and receive 0xA5
    send_word(1'b0, 8'hA5, 1'b1, 1'b0);
    chk("a5_valid", 32'(a_valid), 32'h1);
    chk("a5_word", 32'(a_word), 32'hA5);
    chk("a5_b_valid", 32'(b_valid), 32'h0);
    chk("a5_no_frame_err", 32'(frame_err), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("a5_valid_one_cycle", 32'(a_valid), 32'h0);
    chk("a5_word_held", 32'(a_word), 32'hA5);

    // Interleaved lanes with enable gaps
    for (int j = NB - 1; j >= 0; j--) begin
      step(1'b0, abits[j], 1'b1, 1'b0);
      chk("il_a_valid", 32'(a_valid), (j == 0) ? 32'h1 : 32'h0);
      step(1'b1, bbits[j], 1'b1, 1'b0);
      chk("il_b_valid", 32'(b_valid), (j == 0) ? 32'h1 : 32'h0);
      if (j == 0) begin
        chk("il_a_word", 32'(a_word), 32'h3C);
        chk("il_b_word", 32'(b_word), 32'hC3);
        chk("il_a_valid_dropped", 32'(a_valid), 32'h0);
      end
      if (j == 6 || j == 4 || j == 2) begin
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("il_gap_quiet", {29'h0, a_valid, b_valid, frame_err}, 32'h0);
      end
    end

    // Partial word then resync raises frame_err
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("resync_frame_err", 32'(frame_err), 32'h1);
    chk("resync_a_valid", 32'(a_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resync_frame_err_pulse", 32'(frame_err), 32'h0);
    for (int i = W - 3; i >= 0; i--) step(1'b0, 1'(8'h0F >> i), 1'b1, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
    step(1'b0, ^(8'h0F), 1'b1, 1'b0);
`endif
    chk("resync_a_valid_0f", 32'(a_valid), 32'h1);
    chk("resync_a_word_0f", 32'(a_word), 32'h0F);

    // Back-to-back words on lane B
    send_word(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("b2b_first_valid", 32'(b_valid), 32'h1);
    chk("b2b_first_word", 32'(b_word), 32'h5A);
    send_word(1'b1, 8'h99, 1'b0, 1'b0);
    chk("b2b_second_valid", 32'(b_valid), 32'h1);
    chk("b2b_second_word", 32'(b_word), 32'h99);
    chk("b2b_par_err", 32'(par_err), 32'h0);

    // Asynchronous reset mid-word on lane B
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_a_word", 32'(a_word), 32'h0);
    chk("midrst_b_word", 32'(b_word), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * NB; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("midrst_ignored", {30'h0, a_valid, b_valid}, 32'h0);
    end
    chk("midrst_b_word_held", 32'(b_word), 32'h0);

    // Sync right after reset locks without frame_err
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("relock_no_frame_err", 32'(frame_err), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
    // Parity good then bad on lane A
    send_word(1'b0, 8'h81, 1'b1, 1'b0);
    chk("par_good_valid", 32'(a_valid), 32'h1);
    chk("par_good_word", 32'(a_word), 32'h81);
    chk("par_good_no_err", 32'(par_err), 32'h0);
    send_word(1'b0, 8'h81, 1'b0, 1'b1);
    chk("par_bad_err", 32'(par_err), 32'h1);
    chk("par_bad_valid", 32'(a_valid), 32'h0);
    chk("par_bad_word", 32'(a_word), 32'h81);
    send_word(1'b0, 8'h42, 1'b0, 1'b1);
    chk("par_bad2_err", 32'(par_err), 32'h1);
    chk("par_bad2_word", 32'(a_word), 32'h81);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_err_pulse", 32'(par_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
